// File: rtl/reg_slice_chain.sv
// Cascade of valid/ready register slices. Every stage uses the same cut type:
// BWD (ready cut), FWD (valid/payload cut) or FULL (main + skid, both paths cut).
module reg_slice_chain #(
  parameter int PLD_WIDTH = 32,
  parameter int STAGES    = 2,
  parameter int MODE      = 2,
  parameter int CNT_W     = $clog2(2*STAGES+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 s_vld,
  input  logic [PLD_WIDTH-1:0] s_pld,
  output logic                 s_rdy,
  output logic                 m_vld,
  output logic [PLD_WIDTH-1:0] m_pld,
  input  logic                 m_rdy,
  output logic [CNT_W-1:0]     occ
);

  localparam int MODE_FWD  = 1;
  localparam int MODE_FULL = 2;

  // "main" is the forward register (FWD, FULL); "skid" is the backup entry (BWD, FULL).
  logic [STAGES-1:0]    main_vld;
  logic [STAGES-1:0]    skid_vld;
  logic [PLD_WIDTH-1:0] main_pld [STAGES];
  logic [PLD_WIDTH-1:0] skid_pld [STAGES];

  // Link k is the input side of stage k; link STAGES faces the m_* port.
  logic [STAGES:0]      link_vld;
  logic [STAGES:0]      link_rdy;
  logic [PLD_WIDTH-1:0] link_pld [STAGES+1];

  // Valid/payload only flow forward and ready only backward, so two sweeps suffice.
  always_comb begin
    link_vld = '0;
    link_rdy = '0;
    for (int k = 0; k <= STAGES; k++) begin
      link_pld[k] = '0;
    end
    link_vld[0]      = s_vld;
    link_pld[0]      = s_pld;
    link_rdy[STAGES] = m_rdy;
    for (int k = 0; k < STAGES; k++) begin
      if (MODE == MODE_FULL || MODE == MODE_FWD) begin
        link_vld[k+1] = main_vld[k];
        link_pld[k+1] = main_pld[k];
      end else begin
        link_vld[k+1] = link_vld[k] | skid_vld[k];
        link_pld[k+1] = skid_vld[k] ? skid_pld[k] : link_pld[k];
      end
    end
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (MODE == MODE_FWD) begin
        link_rdy[k] = !main_vld[k] | link_rdy[k+1];
      end else begin
        link_rdy[k] = !skid_vld[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld <= '0;
      skid_vld <= '0;
      for (int k = 0; k < STAGES; k++) begin
        main_pld[k] <= '0;
        skid_pld[k] <= '0;
      end
    end else if (flush) begin
      main_vld <= '0;
      skid_vld <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (MODE == MODE_FULL) begin
          // Main free or draining: refill from skid first, else straight from input.
          if (!main_vld[k] || link_rdy[k+1]) begin
            if (skid_vld[k]) begin
              main_vld[k] <= 1'b1;
              main_pld[k] <= skid_pld[k];
              skid_vld[k] <= 1'b0;
            end else begin
              main_vld[k] <= link_vld[k];
              if (link_vld[k]) begin
                main_pld[k] <= link_pld[k];
              end
            end
          end else if (link_vld[k] && !skid_vld[k]) begin
            skid_vld[k] <= 1'b1;
            skid_pld[k] <= link_pld[k];
          end
        end else if (MODE == MODE_FWD) begin
          if (link_rdy[k]) begin
            main_vld[k] <= link_vld[k];
            if (link_vld[k]) begin
              main_pld[k] <= link_pld[k];
            end
          end
        end else begin
          if (skid_vld[k]) begin
            if (link_rdy[k+1]) begin
              skid_vld[k] <= 1'b0;
            end
          end else if (link_vld[k] && !link_rdy[k+1]) begin
            skid_vld[k] <= 1'b1;
            skid_pld[k] <= link_pld[k];
          end
        end
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int k = 0; k < STAGES; k++) begin
      occ = occ + CNT_W'(main_vld[k]) + CNT_W'(skid_vld[k]);
    end
  end

  // Handshake: a beat moves on an interface at a rising edge where vld & rdy.
  assign m_vld = link_vld[STAGES];
  assign m_pld = link_pld[STAGES];
  assign s_rdy = link_rdy[0] | rst;

endmodule

// File: tb/tb_reg_slice_chain.sv
// Bench for reg_slice_chain: four configurations (FULL/2, BWD/3, FWD/3, FULL/3)
// checked against latency/capacity arithmetic and a FIFO scoreboard.
module tb_reg_slice_chain;

  localparam int W  = 32;
  localparam int CW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]   rst;
  logic [3:0]   flush;
  logic [3:0]   s_vld;
  logic [3:0]   s_rdy;
  logic [3:0]   m_vld;
  logic [3:0]   m_rdy;
  logic [W-1:0] s_pld [4];
  logic [W-1:0] m_pld [4];
  logic [CW-1:0] occ [4];

  int n_tests = 0;
  int n_fail  = 0;

  reg_slice_chain #(.PLD_WIDTH(W), .STAGES(2), .MODE(2)) dut_full2 (
    .clk(clk), .rst(rst[0]), .flush(flush[0]), .s_vld(s_vld[0]), .s_pld(s_pld[0]),
    .s_rdy(s_rdy[0]), .m_vld(m_vld[0]), .m_pld(m_pld[0]), .m_rdy(m_rdy[0]), .occ(occ[0]));
  reg_slice_chain #(.PLD_WIDTH(W), .STAGES(3), .MODE(0)) dut_bwd3 (
    .clk(clk), .rst(rst[1]), .flush(flush[1]), .s_vld(s_vld[1]), .s_pld(s_pld[1]),
    .s_rdy(s_rdy[1]), .m_vld(m_vld[1]), .m_pld(m_pld[1]), .m_rdy(m_rdy[1]), .occ(occ[1]));
  reg_slice_chain #(.PLD_WIDTH(W), .STAGES(3), .MODE(1)) dut_fwd3 (
    .clk(clk), .rst(rst[2]), .flush(flush[2]), .s_vld(s_vld[2]), .s_pld(s_pld[2]),
    .s_rdy(s_rdy[2]), .m_vld(m_vld[2]), .m_pld(m_pld[2]), .m_rdy(m_rdy[2]), .occ(occ[2]));
  reg_slice_chain #(.PLD_WIDTH(W), .STAGES(3), .MODE(2)) dut_full3 (
    .clk(clk), .rst(rst[3]), .flush(flush[3]), .s_vld(s_vld[3]), .s_pld(s_pld[3]),
    .s_rdy(s_rdy[3]), .m_vld(m_vld[3]), .m_pld(m_pld[3]), .m_rdy(m_rdy[3]), .occ(occ[3]));

  function automatic int mode_of(input int d);
    case (d)
      1:       return 0;
      2:       return 1;
      default: return 2;
    endcase
  endfunction

  function automatic int stages_of(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic int cap_of(input int d);
    return (mode_of(d) == 2) ? 2 * stages_of(d) : stages_of(d);
  endfunction

  function automatic int lat_of(input int d);
    return (mode_of(d) == 0) ? 0 : stages_of(d);
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input int d, input string tag);
    check($sformatf("%s%0d_mvld", tag, d), W'(m_vld[d]), W'(0));
    check($sformatf("%s%0d_mpld", tag, d), m_pld[d], W'(0));
    check($sformatf("%s%0d_occ", tag, d), W'(occ[d]), W'(0));
    check($sformatf("%s%0d_srdy", tag, d), W'(s_rdy[d]), W'(1));
  endtask

  // Back-to-back beats 1..n with the sink always ready.
  task automatic latency_test(input int d, input int n);
    int lat;
    int acc;
    int del;
    lat = lat_of(d);
    m_rdy[d] = 1'b1;
    for (int t = 0; t < n + lat + 2; t++) begin
      @(negedge clk);
      s_vld[d] = (t < n);
      s_pld[d] = (t < n) ? W'(t + 1) : '0;
      #1;
      acc = (t < n) ? t : n;
      del = (t - lat < 0) ? 0 : ((t - lat > n) ? n : t - lat);
      check($sformatf("lat%0d_occ_t%0d", d, t), W'(occ[d]), W'(acc - del));
      check($sformatf("lat%0d_mvld_t%0d", d, t), W'(m_vld[d]), W'(t >= lat && t < n + lat));
      if (t >= lat && t < n + lat) begin
        check($sformatf("lat%0d_mpld_t%0d", d, t), m_pld[d], W'(t - lat + 1));
      end
      if (t < n) begin
        check($sformatf("lat%0d_srdy_t%0d", d, t), W'(s_rdy[d]), W'(1));
      end
    end
    @(negedge clk);
    s_vld[d] = 1'b0;
    s_pld[d] = '0;
    m_rdy[d] = 1'b0;
  endtask

  // Fill under stall, drain in order, then reset while stalled.
  task automatic capacity_test(input int d);
    int cap;
    int acc;
    int nxt;
    int exp_out;
    int got;
    cap = cap_of(d);
    acc = 0;
    nxt = 1;
    exp_out = 1;
    got = 0;
    m_rdy[d] = 1'b0;
    for (int t = 0; t < 3 * cap; t++) begin
      @(negedge clk);
      s_vld[d] = 1'b1;
      s_pld[d] = W'(nxt);
      #1;
      if (s_rdy[d]) begin
        acc++;
        nxt++;
      end
    end
    check($sformatf("cap%0d_accepted", d), W'(acc), W'(cap));
    check($sformatf("cap%0d_srdy", d), W'(s_rdy[d]), W'(0));
    check($sformatf("cap%0d_occ", d), W'(occ[d]), W'(cap));
    check($sformatf("cap%0d_mvld", d), W'(m_vld[d]), W'(1));
    check($sformatf("cap%0d_head", d), m_pld[d], W'(1));
    for (int t = 0; t < 4 * cap + 10 && got < 2 * cap; t++) begin
      @(negedge clk);
      m_rdy[d] = 1'b1;
      s_vld[d] = 1'b1;
      s_pld[d] = W'(nxt);
      #1;
      if (s_rdy[d]) nxt++;
      if (m_vld[d]) begin
        check($sformatf("cap%0d_order", d), m_pld[d], W'(exp_out));
        exp_out++;
        got++;
      end
    end
    check($sformatf("cap%0d_drained", d), W'(got), W'(2 * cap));
    for (int t = 0; t < cap + 3; t++) begin
      @(negedge clk);
      m_rdy[d] = 1'b0;
      s_vld[d] = 1'b1;
      s_pld[d] = W'(nxt);
      #1;
      if (s_rdy[d]) nxt++;
    end
    @(negedge clk);
    rst[d]   = 1'b1;
    s_vld[d] = 1'b0;
    s_pld[d] = '0;
    @(negedge clk);
    rst[d] = 1'b0;
    #1;
    chk_idle(d, "stallrst");
  endtask

  task automatic flush_test;
    int nxt;
    nxt = 1;
    m_rdy[0] = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      s_vld[0] = 1'b1;
      s_pld[0] = W'(nxt);
      #1;
      if (s_rdy[0]) nxt++;
    end
    check("flush_pre_occ", W'(occ[0]), W'(4));
    @(negedge clk);
    flush[0] = 1'b1;
    s_vld[0] = 1'b1;
    s_pld[0] = W'(32'hAA);
    @(negedge clk);
    flush[0] = 1'b0;
    s_pld[0] = W'(32'hBB);
    m_rdy[0] = 1'b1;
    #1;
    check("flush_mvld", W'(m_vld[0]), W'(0));
    check("flush_occ", W'(occ[0]), W'(0));
    check("flush_srdy", W'(s_rdy[0]), W'(1));
    @(negedge clk);
    s_vld[0] = 1'b0;
    s_pld[0] = '0;
    #1;
    check("flush_t1_mvld", W'(m_vld[0]), W'(0));
    @(negedge clk);
    #1;
    check("flush_t2_mvld", W'(m_vld[0]), W'(1));
    check("flush_t2_mpld", m_pld[0], W'(32'hBB));
    @(negedge clk);
    #1;
    check("flush_t3_mvld", W'(m_vld[0]), W'(0));
    check("flush_t3_occ", W'(occ[0]), W'(0));
    @(negedge clk);
    m_rdy[0] = 1'b0;
  endtask

  // Random producer/consumer with rare flushes; exp_q holds every beat in flight.
  task automatic soak(input int d, input int beats);
    logic [W-1:0] exp_q[$];
    logic [W-1:0] prev_pld;
    logic         prev_stall;
    logic         hold;
    int           got;
    int           cyc;
    prev_pld   = '0;
    prev_stall = 1'b0;
    hold       = 1'b0;
    got        = 0;
    cyc        = 0;
    while (got < beats && cyc < 6 * beats) begin
      @(negedge clk);
      cyc++;
      flush[d] = ($urandom_range(0, 499) == 0);
      m_rdy[d] = flush[d] ? 1'b0 : 1'($urandom_range(0, 1));
      if (!hold) begin
        s_vld[d] = 1'($urandom_range(0, 1));
        s_pld[d] = $urandom;
      end
      #1;
      check($sformatf("soak%0d_occ", d), W'(occ[d]), W'(exp_q.size()));
      if (prev_stall) begin
        check($sformatf("soak%0d_hold_vld", d), W'(m_vld[d]), W'(1));
        check($sformatf("soak%0d_hold_pld", d), m_pld[d], prev_pld);
      end
      if (flush[d]) begin
        exp_q.delete();
        hold       = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (s_vld[d] && s_rdy[d]) exp_q.push_back(s_pld[d]);
        if (m_vld[d]) begin
          check($sformatf("soak%0d_nonempty", d), W'(exp_q.size() != 0), W'(1));
          if (exp_q.size() != 0) begin
            check($sformatf("soak%0d_pld", d), m_pld[d], exp_q[0]);
            if (m_rdy[d]) begin
              void'(exp_q.pop_front());
              got++;
            end
          end
        end
        hold       = s_vld[d] & ~s_rdy[d];
        prev_stall = m_vld[d] & ~m_rdy[d];
        prev_pld   = m_pld[d];
      end
    end
    check($sformatf("soak%0d_delivered", d), W'(got), W'(beats));
    @(negedge clk);
    flush[d] = 1'b0;
    s_vld[d] = 1'b0;
    m_rdy[d] = 1'b0;
  endtask

  initial begin
    rst   = '1;
    flush = '0;
    s_vld = '0;
    m_rdy = '0;
    for (int d = 0; d < 4; d++) s_pld[d] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    for (int d = 0; d < 4; d++) chk_idle(d, "in_rst");
    @(posedge clk);
    @(negedge clk);
    rst = '0;
    @(negedge clk);
    #1;
    for (int d = 0; d < 4; d++) chk_idle(d, "post_rst");

    for (int d = 0; d < 4; d++) begin
      latency_test(d, 20);
      capacity_test(d);
    end
    flush_test();

    fork
      soak(0, 10000);
      soak(1, 10000);
      soak(2, 10000);
      soak(3, 10000);
    join

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    n_fail++;
    $display("FAIL watchdog: got no completion by %0t expected completion", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
